program_sequencer: RTL and testbench

Program store and issue sequencer for `simple_processor2`: it is the instruction/operand source that sits on the other end of the core's `instruction`/`data_in`/`pc`/`data_out` interface. A host loads a program serially. On command, the sequencer releases the core from reset and issues one instruction per program slot, inserting NOP advance cycles because the core only increments `pc` on NOP-class opcodes. It captures every STORE result into an output FIFO and parks the core when the program ends.

---
 rtl/program_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_program_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// program_sequencer
//
// Program store and issue sequencer for simple_processor2. A host loads a
// program serially as (instruction, operand) byte pairs. On run_start the
// sequencer releases the core from reset and presents one instruction per
// program slot. After every non-NOP, non-JUMP instruction it inserts a NOP
// "advance" cycle, because the core only increments pc on NOP-class opcodes.
// STORE results are captured into a small output FIFO. When pc runs past
// the end of the program, the core is parked on HOLD (0x20).
//
// Handshakes:
//   load_*  : a byte transfers on any cycle with load_valid=1 while
//             load_ready=1 (LOAD state). There is no back-pressure inside LOAD.
//   out_*   : the FIFO head transfers on any cycle with out_valid=1 and
//             out_ready=1. out_byte is stable while out_valid=1 and
//             out_ready=0. A pop while empty is ignored.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   i_load_start        pulse: enter LOAD, clear program length, index, error, FIFO
//   i_load_valid/byte   serial program bytes (even = instruction, odd = operand)
//   i_load_last         marks the final load byte
//   o_load_ready        high in LOAD
//   o_load_err          sticky: a byte arrived after 512 bytes
//   i_run_start         pulse: IDLE -> ISSUE when the program is non-empty
//   i_run_abort         pulse: ISSUE/ADVANCE/DONE -> IDLE
//   i_pc, i_data_out    core program counter and store register
//   o_instruction       instruction byte to the core
//   o_data_in           operand byte to the core
//   o_core_reset        core reset (high in IDLE and LOAD)
//   o_out_valid/byte    FIFO head
//   i_out_ready         consumer pop
//   o_busy, o_done      state is ISSUE/ADVANCE, state is DONE
//   o_dbg_state         current FSM state encoding
module program_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load_start,
    input  logic       i_load_valid,
    input  logic [7:0] i_load_byte,
    input  logic       i_load_last,
    output logic       o_load_ready,
    output logic       o_load_err,
    input  logic       i_run_start,
    input  logic       i_run_abort,
    input  logic [7:0] i_pc,
    input  logic [7:0] i_data_out,
    output logic [7:0] o_instruction,
    output logic [7:0] o_data_in,
    output logic       o_core_reset,
    output logic       o_out_valid,
    output logic [7:0] o_out_byte,
    input  logic       i_out_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic [2:0] o_dbg_state
);

    localparam int CW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] FULL_CNT = (CW+1)'(FIFO_DEPTH);
    localparam logic [7:0] INSTR_HOLD = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ISSUE   = 3'd2,
        S_ADVANCE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [7:0]  r_imem [256];
    logic [7:0]  r_omem [256];
    logic [8:0]  r_prog_len;
    logic [8:0]  r_widx;       // slot index; bit 8 set means the store is full
    logic        r_phase;      // 0: next byte is an instruction, 1: an operand
    logic        r_load_err;
    logic        r_cap_pend;   // STORE issued; capture data_out when ADVANCE closes

    logic [7:0]  r_fifo [FIFO_DEPTH];
    logic [CW-1:0] r_wr_ptr;
    logic [CW-1:0] r_rd_ptr;
    logic [CW:0]   r_count;

    logic [3:0]  w_opcode;
    logic        w_pc_end;
    logic        w_fifo_full;
    logic        w_load_accept;
    logic        w_load_write;
    logic        w_start_cap;
    logic        w_push;
    logic        w_pop;

    assign w_opcode      = r_imem[i_pc][7:4];
    assign w_pc_end      = {1'b0, i_pc} >= r_prog_len;
    assign w_fifo_full   = (r_count == FULL_CNT);
    assign w_load_accept = (r_state == S_LOAD) && i_load_valid && !i_load_start;
    assign w_load_write  = w_load_accept && !r_widx[8];
    assign w_pop         = i_out_ready && (r_count != '0) && !i_load_start;

    // Next state and core-facing outputs.
    always_comb begin
        w_next_state  = r_state;
        o_instruction = 8'h00;
        o_data_in     = 8'h00;
        w_start_cap   = 1'b0;
        w_push        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_run_start && (r_prog_len != 9'd0))
                    w_next_state = S_ISSUE;
            end
            S_LOAD: begin
                if (i_load_valid && i_load_last)
                    w_next_state = S_IDLE;
            end
            S_ISSUE: begin
                if (w_pc_end) begin
                    o_instruction = INSTR_HOLD;
                    w_next_state  = S_DONE;
                end else begin
                    o_instruction = r_imem[i_pc];
                    o_data_in     = r_omem[i_pc];
                    case (w_opcode)
                        4'd1, 4'd3, 4'd4, 4'd5, 4'd6: w_next_state = S_ADVANCE;
                        4'd2: begin
                            // With the FIFO full, STORE is simply re-presented;
                            // the core rewrites the same data_out value.
                            if (!w_fifo_full) begin
                                w_next_state = S_ADVANCE;
                                w_start_cap  = 1'b1;
                            end
                        end
                        // JUMP and NOP-class opcodes move pc themselves.
                        default: w_next_state = S_ISSUE;
                    endcase
                end
                if (i_run_abort) begin
                    w_next_state = S_IDLE;
                    w_start_cap  = 1'b0;
                end
            end
            S_ADVANCE: begin
                w_push       = r_cap_pend;
                w_next_state = S_ISSUE;
                if (i_run_abort) begin
                    w_next_state = S_IDLE;
                    w_push       = 1'b0;
                end
            end
            S_DONE: begin
                o_instruction = INSTR_HOLD;
                if (i_run_abort)
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase

        if (i_load_start) begin
            w_next_state = S_LOAD;
            w_start_cap  = 1'b0;
            w_push       = 1'b0;
        end
    end

    // State, load bookkeeping and FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_prog_len <= 9'd0;
            r_widx     <= 9'd0;
            r_phase    <= 1'b0;
            r_load_err <= 1'b0;
            r_cap_pend <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_next_state;
            r_cap_pend <= w_start_cap;

            if (i_load_start) begin
                r_prog_len <= 9'd0;
                r_widx     <= 9'd0;
                r_phase    <= 1'b0;
                r_load_err <= 1'b0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_load_accept) begin
                    if (r_widx[8]) begin
                        r_load_err <= 1'b1;
                    end else if (!r_phase) begin
                        r_prog_len <= r_widx + 9'd1;
                        r_phase    <= 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        r_widx  <= r_widx + 9'd1;
                    end
                end

                if (w_push)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= r_count + (CW+1)'(w_push) - (CW+1)'(w_pop);
            end
        end
    end

    // Storage arrays carry no reset.
    always_ff @(posedge clk) begin
        if (w_load_write) begin
            if (!r_phase) begin
                r_imem[r_widx[7:0]] <= i_load_byte;
                // A trailing instruction with no operand byte keeps operand 0.
                r_omem[r_widx[7:0]] <= 8'h00;
            end else begin
                r_omem[r_widx[7:0]] <= i_load_byte;
            end
        end
        if (w_push && !reset)
            r_fifo[r_wr_ptr] <= i_data_out;
    end

    assign o_load_ready = (r_state == S_LOAD);
    assign o_load_err   = r_load_err;
    assign o_core_reset = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign o_busy       = (r_state == S_ISSUE) || (r_state == S_ADVANCE);
    assign o_done       = (r_state == S_DONE);
    assign o_out_valid  = (r_count != '0);
    assign o_out_byte   = o_out_valid ? r_fifo[r_rd_ptr] : 8'h00;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_program_sequencer.sv
// Testbench for program_sequencer. Contains a small behavioural model of the
// simple_processor2 core, so programs really execute against the sequencer.
// STORE results are checked through an expected-byte queue.
module tb_program_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_start = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_byte = 8'h00;
    logic       load_last = 1'b0;
    logic       load_ready;
    logic       load_err;
    logic       run_start = 1'b0;
    logic       run_abort = 1'b0;
    logic [7:0] core_pc;
    logic [7:0] core_dout;
    logic [7:0] core_acc;
    logic [7:0] instruction;
    logic [7:0] data_in;
    logic       core_reset;
    logic       out_valid;
    logic [7:0] out_byte;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] prog_q[$];

    localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_ISSUE = 3'd2,
                           ST_ADVANCE = 3'd3, ST_DONE = 3'd4;

    program_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_load_start  (load_start),
        .i_load_valid  (load_valid),
        .i_load_byte   (load_byte),
        .i_load_last   (load_last),
        .o_load_ready  (load_ready),
        .o_load_err    (load_err),
        .i_run_start   (run_start),
        .i_run_abort   (run_abort),
        .i_pc          (core_pc),
        .i_data_out    (core_dout),
        .o_instruction (instruction),
        .o_data_in     (data_in),
        .o_core_reset  (core_reset),
        .o_out_valid   (out_valid),
        .o_out_byte    (out_byte),
        .i_out_ready   (out_ready),
        .o_busy        (busy),
        .o_done        (done),
        .o_dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- core model ----------------
    always @(posedge clk) begin
        if (core_reset) begin
            core_pc   <= 8'h00;
            core_acc  <= 8'h00;
            core_dout <= 8'h00;
        end else begin
            case (instruction[7:4])
                4'd1: core_acc  <= data_in;
                4'd2: core_dout <= core_acc;
                4'd3: core_acc  <= core_acc + data_in;
                4'd4: core_acc  <= core_acc - data_in;
                4'd5: core_acc  <= core_acc & data_in;
                4'd6: core_acc  <= core_acc | data_in;
                4'd7: core_pc   <= instruction;
                default: core_pc <= core_pc + 8'd1;
            endcase
        end
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0)
                check("sb_unexpected_pop", {24'h0, out_byte}, 32'hFFFF_FFFF);
            else
                check("sb_byte", {24'h0, out_byte}, {24'h0, exp_q.pop_front()});
        end
    end

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_prog();
        tick(1);
        load_start = 1'b1;
        tick(1);
        load_start = 1'b0;
        for (int i = 0; i < prog_q.size(); i++) begin
            load_valid = 1'b1;
            load_byte  = prog_q[i];
            load_last  = (i == prog_q.size() - 1);
            tick(1);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic pulse_run();
        tick(1);
        run_start = 1'b1;
        tick(1);
        run_start = 1'b0;
    endtask

    // Counts edges after the edge that sampled run_start.
    task automatic run_timed(input int budget, output int k_valid, output int k_done);
        int k;
        pulse_run();
        k = 0;
        k_valid = -1;
        k_done = -1;
        while (k < budget) begin
            tick(1);
            k++;
            if (out_valid && k_valid < 0) k_valid = k;
            if (done) begin
                k_done = k;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_core_reset"}, {31'h0, core_reset}, 32'd1);
        check({pfx, "_instruction"}, {24'h0, instruction}, 32'h0);
        check({pfx, "_data_in"}, {24'h0, data_in}, 32'h0);
        check({pfx, "_load_ready"}, {31'h0, load_ready}, 32'd0);
        check({pfx, "_load_err"}, {31'h0, load_err}, 32'd0);
        check({pfx, "_out_valid"}, {31'h0, out_valid}, 32'd0);
        check({pfx, "_out_byte"}, {24'h0, out_byte}, 32'h0);
        check({pfx, "_busy"}, {31'h0, busy}, 32'd0);
        check({pfx, "_done"}, {31'h0, done}, 32'd0);
        check({pfx, "_state"}, {29'h0, dbg_state}, {29'h0, ST_IDLE});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int kv, kd, budget;

        tick(3);
        reset = 1'b0;
        check_reset_outputs("rst");
        check("rst_prog_len", {23'h0, dut.r_prog_len}, 32'd0);

        // Test 1: load 5, add 3, store -> 0x08
        prog_q = '{8'h10, 8'h05, 8'h30, 8'h03, 8'h20, 8'h00};
        load_prog();
        check("t1_prog_len", {23'h0, dut.r_prog_len}, 32'd3);
        check("t1_idle", {29'h0, dbg_state}, {29'h0, ST_IDLE});
        exp_q.push_back(8'h08);
        out_ready = 1'b0;
        run_timed(50, kv, kd);
        check("t1_valid_latency", kv, 32'd6);
        check("t1_done_latency", kd, 32'd7);
        check("t1_hold_instr", {24'h0, instruction}, 32'h20);
        tick(3);
        check("t1_hold_instr_later", {24'h0, instruction}, 32'h20);
        check("t1_run_ignored_done", {31'h0, done}, 32'd1);
        out_ready = 1'b1;
        tick(3);
        check("t1_drained", exp_q.size(), 32'd0);
        check("t1_empty", {31'h0, out_valid}, 32'd0);

        // Test 2: five STOREs into a 4-entry FIFO, random consumer
        prog_q = '{8'h10, 8'hAA, 8'h20, 8'h00, 8'h20, 8'h00,
                   8'h20, 8'h00, 8'h20, 8'h00, 8'h20, 8'h00};
        out_ready = 1'b0;
        load_prog();
        for (int i = 0; i < 5; i++) exp_q.push_back(8'hAA);
        pulse_run();
        tick(40);
        check("t2_hold_state", {29'h0, dbg_state}, {29'h0, ST_ISSUE});
        check("t2_hold_pc", {24'h0, core_pc}, 32'd5);
        check("t2_fifo_count", {29'h0, dut.r_count}, 32'd4);
        check("t2_busy", {31'h0, busy}, 32'd1);
        check("t2_head", {24'h0, out_byte}, 32'hAA);
        budget = 200;
        while (!done && budget > 0) begin
            out_ready = 1'($urandom_range(0, 1));
            tick(1);
            budget--;
        end
        check("t2_done", {31'h0, done}, 32'd1);
        out_ready = 1'b1;
        tick(6);
        check("t2_drained", exp_q.size(), 32'd0);

        // Test 3: two 1-cycle NOPs, then load 7 and store
        prog_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h07, 8'h20, 8'h00};
        load_prog();
        exp_q.push_back(8'h07);
        run_timed(50, kv, kd);
        check("t3_valid_latency", kv, 32'd6);
        check("t3_done_latency", kd, 32'd7);
        tick(2);
        check("t3_drained", exp_q.size(), 32'd0);

        // Test 4: JUMP past the program end
        prog_q = '{8'h72, 8'h00};
        load_prog();
        check("t4_prog_len", {23'h0, dut.r_prog_len}, 32'd1);
        run_timed(20, kv, kd);
        check("t4_done_latency", kd, 32'd2);
        check("t4_core_pc", {24'h0, core_pc}, 32'h72);
        check("t4_no_output", kv, 32'hFFFF_FFFF);

        // Test 5: abort during the ADVANCE of a STORE
        prog_q = '{8'h10, 8'h05, 8'h20, 8'h00};
        load_prog();
        pulse_run();
        tick(3);
        check("t5_in_advance", {29'h0, dbg_state}, {29'h0, ST_ADVANCE});
        run_abort = 1'b1;
        tick(1);
        run_abort = 1'b0;
        check("t5_core_reset", {31'h0, core_reset}, 32'd1);
        check("t5_idle", {29'h0, dbg_state}, {29'h0, ST_IDLE});
        tick(2);
        check("t5_no_push", {31'h0, out_valid}, 32'd0);

        // load_start beats run_start in IDLE
        load_start = 1'b1;
        run_start  = 1'b1;
        tick(1);
        load_start = 1'b0;
        run_start  = 1'b0;
        check("t5_load_wins", {29'h0, dbg_state}, {29'h0, ST_LOAD});
        check("t5_load_ready", {31'h0, load_ready}, 32'd1);
        check("t5_core_reset_load", {31'h0, core_reset}, 32'd1);

        // Test 6: 513 load bytes; first pair loads 0xAA, next pair stores,
        // the rest are NOPs so the run loops forever.
        tick(1);
        load_start = 1'b1;
        tick(1);
        load_start = 1'b0;
        for (int i = 0; i < 513; i++) begin
            if (i == 512)
                check("t6_no_err_at_512", {31'h0, load_err}, 32'd0);
            load_valid = 1'b1;
            load_byte  = (i == 0) ? 8'h10 : (i == 1) ? 8'hAA : (i == 2) ? 8'h20 : 8'h00;
            load_last  = (i == 512);
            tick(1);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("t6_load_err", {31'h0, load_err}, 32'd1);
        check("t6_prog_len", {23'h0, dut.r_prog_len}, 32'd256);
        check("t6_idle", {29'h0, dbg_state}, {29'h0, ST_IDLE});

        // Test 7: reset in the middle of that run
        out_ready = 1'b0;
        pulse_run();
        tick(10);
        check("t7_busy", {31'h0, busy}, 32'd1);
        check("t7_head", {24'h0, out_byte}, 32'hAA);
        reset = 1'b1;
        tick(1);
        check_reset_outputs("t7");
        reset = 1'b0;
        tick(2);
        check("t7_stays_idle", {29'h0, dbg_state}, {29'h0, ST_IDLE});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
